// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ctrl_pkg
// Description : Shared encodings for the multicycle controller. It holds the
//               state codes, supported opcode and funct values, the alu_ctrl
//               codes, the pc_src and alu_src_b mux selects, and a helper
//               that tells whether an opcode is supported.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // State encoding; the codes are visible on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SL2 = 2'd3;

  // True for opcodes the controller can sequence. The funct field of an
  // R-type instruction is checked separately.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : multicycle_ctrl_if
// Description : Bundle between the multicycle controller and the datapath.
//   Controller inputs : opcode[5:0], funct[5:0], zero, mem_ready
//   Controller outputs: pc_write, pc_src[1:0], ir_write, mem_read, mem_write,
//                       reg_write, reg_dst, mem_to_reg, alu_src_a,
//                       alu_src_b[1:0], alu_ctrl[3:0], illegal, state[2:0]
//   Modports          : master = controller side, slave = datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_dec
// Description : Combinational ALU operation decode for the multicycle
//               controller.
//   state       in  3  current controller state
//   opcode      in  6  opcode to decode (live in DECODE, latched afterwards)
//   funct       in  6  funct to decode (live in DECODE, latched afterwards)
//   alu_ctrl    out 4  ALU operation for this state
//   rtype_legal out 1  funct is one of the supported R-type operations
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       rtype_legal
);

  logic [3:0] w_fn_alu;

  always_comb begin
    w_fn_alu    = ALU_AND;
    rtype_legal = 1'b1;
    case (funct)
      FN_ADD:  w_fn_alu = ALU_ADD;
      FN_SUB:  w_fn_alu = ALU_SUB;
      FN_AND:  w_fn_alu = ALU_AND;
      FN_OR:   w_fn_alu = ALU_OR;
      FN_SLT:  w_fn_alu = ALU_SLT;
      default: rtype_legal = 1'b0;
    endcase
  end

  // FETCH computes PC+4 and DECODE the branch target, so both add. The
  // instruction's own operation is held through MEM and WB so that the ALU
  // result stays stable while it is consumed.
  always_comb begin
    alu_ctrl = ALU_AND;
    case (state)
      ST_FETCH, ST_DECODE: alu_ctrl = ALU_ADD;
      ST_EXEC, ST_MEM, ST_WB: begin
        case (opcode)
          OP_RTYPE:            alu_ctrl = w_fn_alu;
          OP_LW, OP_SW, OP_ADDI: alu_ctrl = ALU_ADD;
          OP_BEQ:              alu_ctrl = ALU_SUB;
          default:             alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle control FSM that sequences fetch, decode,
//               execute, memory access and writeback. It drives the PC, IR,
//               memory, register-file and ALU strobes.
//   clk   in  1  system clock, rising edge
//   reset in  1  synchronous, active-high reset
//   bus   master modport of multicycle_ctrl_if. It carries opcode, funct,
//         zero and mem_ready in, and all control strobes plus the debug
//         state out.
// Parameter   : MEM_TIMEOUT - maximum number of mem_ready wait cycles in
//               FETCH/MEM; 0 waits forever.
// Build macro : ILLEGAL_TRAP_EN - if defined, an unsupported instruction or a
//               memory timeout parks the FSM in TRAP with a sticky illegal
//               flag. If undefined, an unsupported instruction acts as a NOP,
//               with illegal pulsing for its DECODE cycle, and a timeout
//               returns to FETCH.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t FAULT_DEST = ST_TRAP;
`else
  localparam state_t FAULT_DEST = ST_FETCH;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [5:0]       r_op;
  logic [5:0]       r_fn;
  logic [CNT_W-1:0] r_wait_cnt;

  logic [5:0] w_dec_op;
  logic [5:0] w_dec_fn;
  logic [3:0] w_alu_ctrl;
  logic       w_rtype_legal;
  logic       w_instr_legal;
  logic       w_waiting;
  logic       w_timeout;

  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_ir_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_illegal;

  // The IR is loaded at the end of FETCH, so the decoder fields first become
  // valid during DECODE. That cycle has to look at them live. Every later
  // state uses the copies latched at the end of DECODE.
  assign w_dec_op = (r_state == ST_DECODE) ? bus.opcode : r_op;
  assign w_dec_fn = (r_state == ST_DECODE) ? bus.funct  : r_fn;

  alu_ctrl_dec u_alu_ctrl_dec (
    .state       (r_state),
    .opcode      (w_dec_op),
    .funct       (w_dec_fn),
    .alu_ctrl    (w_alu_ctrl),
    .rtype_legal (w_rtype_legal)
  );

  assign w_instr_legal = op_supported(w_dec_op) &&
                         ((w_dec_op != OP_RTYPE) || w_rtype_legal);

  assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !bus.mem_ready;
  // Fires on the MEM_TIMEOUT-th consecutive wait cycle.
  assign w_timeout = (MEM_TIMEOUT > 0) && w_waiting && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_fn       <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_op <= bus.opcode;
        r_fn <= bus.funct;
      end
      // The counter holds zero except while a wait is in progress, so each
      // entry into FETCH/MEM starts counting afresh.
      if ((MEM_TIMEOUT > 0) && w_waiting && !w_timeout)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else
        r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready)  w_state_next = ST_DECODE;
        else if (w_timeout) w_state_next = FAULT_DEST;
      end
      ST_DECODE: w_state_next = w_instr_legal ? ST_EXEC : FAULT_DEST;
      ST_EXEC: begin
        case (r_op)
          OP_RTYPE, OP_ADDI: w_state_next = ST_WB;
          OP_LW, OP_SW:      w_state_next = ST_MEM;
          default:           w_state_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready)  w_state_next = (r_op == OP_LW) ? ST_WB : ST_FETCH;
        else if (w_timeout) w_state_next = FAULT_DEST;
      end
      ST_WB:   w_state_next = ST_FETCH;
      ST_TRAP: w_state_next = ST_TRAP;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_pc_src     = PC_SRC_SEQ;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRC_B_RT;
    w_illegal    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRC_B_FOUR;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      ST_DECODE: begin
        w_alu_src_b = SRC_B_IMM_SL2;
        w_illegal   = !w_instr_legal;
      end
      ST_EXEC: begin
        case (r_op)
          OP_RTYPE: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRC_B_RT;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRC_B_IMM;
          end
          OP_BEQ: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRC_B_RT;
            w_pc_src    = PC_SRC_BRANCH;
            w_pc_write  = bus.zero;
          end
          OP_J: begin
            w_pc_src   = PC_SRC_JUMP;
            w_pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        w_mem_read  = (r_op == OP_LW);
        w_mem_write = (r_op == OP_SW);
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (r_op == OP_RTYPE);
        w_mem_to_reg = (r_op == OP_LW);
      end
      ST_TRAP: w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are masked while reset is high so that no architectural
  // state changes on the edge that resets the controller.
  assign bus.pc_write   = w_pc_write  & ~reset;
  assign bus.ir_write   = w_ir_write  & ~reset;
  assign bus.mem_write  = w_mem_write & ~reset;
  assign bus.reg_write  = w_reg_write & ~reset;
  assign bus.pc_src     = w_pc_src;
  assign bus.mem_read   = w_mem_read;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_ctrl   = w_alu_ctrl;
  assign bus.illegal    = w_illegal;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each instruction is
//               expanded into its expected per-cycle trace of state and
//               strobes from the instruction's class, its memory wait counts
//               and the zero flag. The bench then drives the trace and
//               compares every cycle. The bench honours ILLEGAL_TRAP_EN in
//               the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int T = 5;  // MEM_TIMEOUT used for the DUT
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_MODE = 1'b1;
`else
  localparam bit TRAP_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [19:0] dut_vec;
  assign dut_vec = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read,
                    bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.illegal,
                    bus.state};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [19:0] exp;
    string       tag;
  } cyc_t;

  cyc_t q[$];

  // Expected output word, same field order as dut_vec.
  function automatic logic [19:0] ov(int st, bit pcw, int pcs, bit irw, bit mr, bit mw,
                                     bit rw, bit rd, bit m2r, bit sa, int sb, int alu, bit ill);
    return {pcw, pcs[1:0], irw, mr, mw, rw, rd, m2r, sa, sb[1:0], alu[3:0], ill, st[2:0]};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(bit rst, bit rdy, bit z, logic [5:0] op, logic [5:0] fn,
                               logic [19:0] exp, string tag);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.z = z; c.op = op; c.fn = fn; c.exp = exp; c.tag = tag;
    q.push_back(c);
  endfunction

  function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                            (fn == 6'h25) || (fn == 6'h2A);
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
  endfunction

  function automatic int r_alu(logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h25: return 1;
      6'h2A: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic void do_reset(logic [19:0] first_exp, int n);
    push(1, rb(), rb(), 6'($urandom), 6'($urandom), first_exp, "reset_first");
    for (int i = 1; i < n; i++)
      push(1, rb(), rb(), 6'($urandom), 6'($urandom), 20'h0, "reset_idle");
    push(0, rb(), rb(), 6'($urandom), 6'($urandom), 20'h0, "reset_release_idle");
  endfunction

  function automatic void trap_then_reset(int n);
    logic [19:0] tv;
    tv = ov(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < n; i++)
      push(0, rb(), rb(), 6'($urandom), 6'($urandom), tv, "trap_hold");
    do_reset(tv, 2);
  endfunction

  // Appends the expected trace of one instruction. A return value of 1 means
  // the instruction ended in TRAP, and the caller must append the trap hold
  // and the reset.
  function automatic bit gen_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw, bit z, string tag);
    logic [19:0] fwait, fdone, ex_mem, mv;
    int fa;
    bit lw;
    fwait  = ov(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    fdone  = ov(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    ex_mem = ov(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    fa     = r_alu(fn);
    lw     = (op == 6'h23);
    if (fw >= T) begin
      for (int i = 0; i < T; i++) push(0, 0, rb(), op, fn, fwait, {tag, "/fetch_to"});
      if (TRAP_MODE) return 1'b1;
    end else begin
      for (int i = 0; i < fw; i++) push(0, 0, rb(), op, fn, fwait, {tag, "/fetch_wait"});
    end
    push(0, 1, rb(), op, fn, fdone, {tag, "/fetch"});
    push(0, rb(), rb(), op, fn, ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, !is_legal(op, fn)),
         {tag, "/decode"});
    if (!is_legal(op, fn)) return TRAP_MODE;
    case (op)
      6'h00: begin
        push(0, rb(), rb(), 6'($urandom), 6'($urandom),
             ov(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, fa, 0), {tag, "/exec_r"});
        push(0, rb(), rb(), 6'($urandom), 6'($urandom),
             ov(5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, fa, 0), {tag, "/wb_r"});
      end
      6'h08: begin
        push(0, rb(), rb(), 6'($urandom), 6'($urandom), ex_mem, {tag, "/exec_addi"});
        push(0, rb(), rb(), 6'($urandom), 6'($urandom),
             ov(5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0), {tag, "/wb_addi"});
      end
      6'h23, 6'h2B: begin
        mv = ov(4, 0, 0, 0, lw, !lw, 0, 0, 0, 0, 0, 2, 0);
        push(0, rb(), rb(), 6'($urandom), 6'($urandom), ex_mem, {tag, "/exec_mem"});
        if (mw >= T) begin
          for (int i = 0; i < T; i++)
            push(0, 0, rb(), 6'($urandom), 6'($urandom), mv, {tag, "/mem_to"});
          return TRAP_MODE;
        end
        for (int i = 0; i < mw; i++)
          push(0, 0, rb(), 6'($urandom), 6'($urandom), mv, {tag, "/mem_wait"});
        push(0, 1, rb(), 6'($urandom), 6'($urandom), mv, {tag, "/mem"});
        if (lw)
          push(0, rb(), rb(), 6'($urandom), 6'($urandom),
               ov(5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2, 0), {tag, "/wb_lw"});
      end
      6'h04: push(0, rb(), z, 6'($urandom), 6'($urandom),
                  ov(3, z, 1, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0), {tag, "/exec_beq"});
      default: push(0, rb(), rb(), 6'($urandom), 6'($urandom),
                    ov(3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {tag, "/exec_j"});
    endcase
    return 1'b0;
  endfunction

  function automatic void gen_random(int n);
    logic [5:0] ops[5];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    int k;
    ops = '{6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, TRAP_MODE ? 9 : 10);
      fn = 6'($urandom);
      if (k < 5) begin op = 6'h00; fn = fns[k]; end
      else if (k < 10) op = ops[k-5];
      else begin op = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'h00; fn = 6'h3F; end
      void'(gen_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                      $sformatf("rnd%0d", i)));
    end
  endfunction

  initial begin
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = '0;
    bus.funct     = '0;

    do_reset(20'h0, 3);
    // add $8,$9,$10
    void'(gen_instr(6'h00, 6'h20, 0, 0, 0, "add"));
    void'(gen_instr(6'h23, 6'h00, 0, 2, 0, "lw_wait2"));
    void'(gen_instr(6'h04, 6'h00, 0, 0, 1, "beq_taken"));
    void'(gen_instr(6'h04, 6'h00, 0, 0, 0, "beq_not"));
    void'(gen_instr(6'h2B, 6'h00, 1, 1, 0, "sw"));
    void'(gen_instr(6'h08, 6'h00, 2, 0, 0, "addi"));
    void'(gen_instr(6'h02, 6'h00, 0, 0, 0, "j"));
    gen_random(25);

    // Unsupported opcode
    if (gen_instr(6'h3F, 6'h00, 0, 0, 0, "ill_op")) trap_then_reset(10);
    void'(gen_instr(6'h00, 6'h22, 0, 0, 0, "sub_after_ill"));
    // R-type with an unsupported funct
    if (gen_instr(6'h00, 6'h3F, 0, 0, 0, "ill_fn")) trap_then_reset(3);
    void'(gen_instr(6'h00, 6'h2A, 0, 0, 0, "slt"));

    // SW held in MEM, then reset mid-wait: no write strobe on that edge
    push(0, 1, 0, 6'h2B, 6'h00, ov(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0), "swrst/fetch");
    push(0, 0, 0, 6'h2B, 6'h00, ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0), "swrst/decode");
    push(0, 0, 0, 6'h11, 6'h11, ov(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0), "swrst/exec");
    push(0, 0, 0, 6'h11, 6'h11, ov(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0), "swrst/mem_wait");
    push(1, 0, 0, 6'h11, 6'h11, ov(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "swrst/mem_reset");
    push(0, 0, 0, 6'h11, 6'h11, 20'h0, "swrst/idle");
    void'(gen_instr(6'h00, 6'h25, 0, 0, 0, "or_after_rst"));

    // Memory timeouts
    if (gen_instr(6'h23, 6'h00, 0, T, 0, "lw_timeout")) trap_then_reset(4);
    if (gen_instr(6'h00, 6'h24, T, 0, 0, "fetch_timeout")) trap_then_reset(4);
    void'(gen_instr(6'h23, 6'h00, T - 1, T - 1, 0, "lw_max_wait"));
    gen_random(15);

    @(posedge clk);
    foreach (q[i]) begin
      #1;
      reset         = q[i].rst;
      bus.mem_ready = q[i].rdy;
      bus.zero      = q[i].z;
      bus.opcode    = q[i].op;
      bus.funct     = q[i].fn;
      @(negedge clk);
      check_value($sformatf("%s@%0d", q[i].tag, i), dut_vec, q[i].exp);
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
